// File: rtl/fu_issue_queue.sv
// fu_issue_queue: sorts issued FU packets into per-class circular FIFOs
// (ALU, MULT, LOAD, STORE) and hands the oldest entries of each class to
// that class's FU lanes whenever the lanes signal avail.

package fu_pkg;
  typedef struct packed {
    logic        valid;
    logic [5:0]  robn;
    logic [3:0]  opcode;
    logic [31:0] op1;
    logic [31:0] op2;
  } FU_PACKET;
endpackage

// One class FIFO: picks its own class out of the issue lanes, presents
// its oldest entries to the available lanes in ascending lane order.
module fu_class_fifo
  import fu_pkg::*;
#(
  parameter int         N_IN    = 4,
  parameter int         N_LANE  = 3,
  parameter int         Q_DEPTH = 8,
  parameter logic [1:0] CLS     = 2'd0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             squash,
  input  FU_PACKET [N_IN-1:0]              issue_packet,
  input  logic [N_IN-1:0][1:0]             issue_class,
  input  logic [N_LANE-1:0]                avail,
  output FU_PACKET [N_LANE-1:0]            lane_packet,
  output logic [$clog2(Q_DEPTH+1)-1:0]     free,
  output logic                             ovf_set
);

  localparam int CW = $clog2(Q_DEPTH + 1);
  localparam int PW = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;

  FU_PACKET      mem [Q_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] deq_n;
  logic [CW-1:0] enq_n;
  logic [CW-1:0] space;
  logic [CW-1:0] count_next;
  logic [N_IN-1:0] wr_en;
  logic [PW-1:0] wr_idx [N_IN];

  // Pointer plus offset modulo Q_DEPTH; offset never exceeds Q_DEPTH so a
  // single conditional subtract is enough and non-power-of-2 depths work.
  function automatic logic [PW-1:0] wrap_ptr(input logic [PW-1:0] base,
                                             input logic [CW-1:0] off);
    logic [CW:0] sum;
    sum = (CW+1)'(base) + (CW+1)'(off);
    if (sum >= (CW+1)'(Q_DEPTH)) sum = sum - (CW+1)'(Q_DEPTH);
    return sum[PW-1:0];
  endfunction

  // Presentation: k-th oldest entry drives the k-th available lane.
  always_comb begin
    lane_packet = '0;
    deq_n       = '0;
    for (int i = 0; i < N_LANE; i++) begin
      if (avail[i] && (deq_n < count) && !reset && !squash) begin
        lane_packet[i]       = mem[wrap_ptr(head, deq_n)];
        lane_packet[i].valid = 1'b1;
        deq_n                = deq_n + CW'(1);
      end
    end
  end

  // Enqueue selection: own-class lanes in ascending order, limited by the
  // space at the start of the cycle; anything beyond that is dropped.
  always_comb begin
    enq_n   = '0;
    ovf_set = 1'b0;
    wr_en   = '0;
    space   = CW'(Q_DEPTH) - count;
    for (int i = 0; i < N_IN; i++) wr_idx[i] = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (issue_packet[i].valid && (issue_class[i] == CLS)) begin
        if (enq_n < space) begin
          wr_en[i]  = 1'b1;
          wr_idx[i] = wrap_ptr(tail, enq_n);
          enq_n     = enq_n + CW'(1);
        end else begin
          ovf_set = 1'b1;
        end
      end
    end
    if (reset || squash) begin
      wr_en   = '0;
      enq_n   = '0;
      ovf_set = 1'b0;
    end
    count_next = count + enq_n - deq_n;
  end

  // Control state: pointers, occupancy and the registered free count.
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      free  <= CW'(Q_DEPTH);
    end else begin
      head  <= wrap_ptr(head, deq_n);
      tail  <= wrap_ptr(tail, enq_n);
      count <= count_next;
      free  <= CW'(Q_DEPTH) - count_next;
    end
  end

  // Entry storage; only written on accepted enqueues, never reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_IN; i++) begin
      if (wr_en[i]) mem[wr_idx[i]] <= issue_packet[i];
    end
  end

endmodule

// Top level: four class FIFOs plus the sticky overflow flag.
module fu_issue_queue
  import fu_pkg::*;
#(
  parameter int N_IN    = 4,
  parameter int N_ALU   = 3,
  parameter int N_MULT  = 2,
  parameter int N_LOAD  = 2,
  parameter int N_STORE = 1,
  parameter int Q_DEPTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         squash,
  input  FU_PACKET [N_IN-1:0]          issue_packet,
  input  logic [N_IN-1:0][1:0]         issue_class,
  input  logic [N_ALU-1:0]             alu_avail,
  input  logic [N_MULT-1:0]            mult_avail,
  input  logic [N_LOAD-1:0]            load_avail,
  input  logic [N_STORE-1:0]           store_avail,
  output FU_PACKET [N_ALU-1:0]         fu_alu_packet,
  output FU_PACKET [N_MULT-1:0]        fu_mult_packet,
  output FU_PACKET [N_LOAD-1:0]        fu_load_packet,
  output FU_PACKET [N_STORE-1:0]       fu_store_packet,
  output logic [$clog2(Q_DEPTH+1)-1:0] alu_free,
  output logic [$clog2(Q_DEPTH+1)-1:0] mult_free,
  output logic [$clog2(Q_DEPTH+1)-1:0] load_free,
  output logic [$clog2(Q_DEPTH+1)-1:0] store_free,
  output logic                         overflow
);

  logic alu_ovf;
  logic mult_ovf;
  logic load_ovf;
  logic store_ovf;

  fu_class_fifo #(.N_IN(N_IN), .N_LANE(N_ALU), .Q_DEPTH(Q_DEPTH), .CLS(2'd0)) u_alu (
    .clock(clock), .reset(reset), .squash(squash),
    .issue_packet(issue_packet), .issue_class(issue_class),
    .avail(alu_avail), .lane_packet(fu_alu_packet), .free(alu_free), .ovf_set(alu_ovf)
  );

  fu_class_fifo #(.N_IN(N_IN), .N_LANE(N_MULT), .Q_DEPTH(Q_DEPTH), .CLS(2'd1)) u_mult (
    .clock(clock), .reset(reset), .squash(squash),
    .issue_packet(issue_packet), .issue_class(issue_class),
    .avail(mult_avail), .lane_packet(fu_mult_packet), .free(mult_free), .ovf_set(mult_ovf)
  );

  fu_class_fifo #(.N_IN(N_IN), .N_LANE(N_LOAD), .Q_DEPTH(Q_DEPTH), .CLS(2'd2)) u_load (
    .clock(clock), .reset(reset), .squash(squash),
    .issue_packet(issue_packet), .issue_class(issue_class),
    .avail(load_avail), .lane_packet(fu_load_packet), .free(load_free), .ovf_set(load_ovf)
  );

  fu_class_fifo #(.N_IN(N_IN), .N_LANE(N_STORE), .Q_DEPTH(Q_DEPTH), .CLS(2'd3)) u_store (
    .clock(clock), .reset(reset), .squash(squash),
    .issue_packet(issue_packet), .issue_class(issue_class),
    .avail(store_avail), .lane_packet(fu_store_packet), .free(store_free), .ovf_set(store_ovf)
  );

  // Sticky overflow: set by any dropped enqueue, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) overflow <= 1'b0;
    else if (alu_ovf || mult_ovf || load_ovf || store_ovf) overflow <= 1'b1;
  end

endmodule

// File: doc/fu_issue_queue.md
Name: fu_issue_queue

Overview:
- Transmitter side of the FU packet/avail interface consumed by fu_cdb.
- Accepts up to `N issued FU_PACKETs per cycle from the RS and sorts them into four per-class FIFOs: ALU, MULT, LOAD, STORE.
- Presents the oldest entries of each class to that class's FU lanes, and dequeues an entry only when its lane's avail bit is high.
- Reports free slots per class back to the RS for flow control.

Parameters:
- N_IN, `N: issue lanes in per cycle.
- N_ALU, `NUM_FU_ALU: ALU FU lanes.
- N_MULT, `NUM_FU_MULT: MULT FU lanes.
- N_LOAD, `NUM_FU_LOAD: LOAD FU lanes.
- N_STORE, `NUM_FU_STORE: STORE FU lanes.
- Q_DEPTH, 8: entries per class FIFO; must be ≥ max(N_IN, lanes of class).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- squash  in  1  flush all queued work (mispredict)
- issue_packet  in  [N_IN-1:0] FU_PACKET  incoming instructions; .valid qualifies each lane
- issue_class  in  [N_IN-1:0][1:0]  per-lane class: 0 ALU, 1 MULT, 2 LOAD, 3 STORE
- alu_avail  in  N_ALU  lane i accepts a packet this cycle
- mult_avail  in  N_MULT  lane i accepts a packet this cycle
- load_avail  in  N_LOAD  lane i accepts a packet this cycle
- store_avail  in  N_STORE  lane i accepts a packet this cycle
- fu_alu_packet  out  [N_ALU-1:0] FU_PACKET  ALU lane packets
- fu_mult_packet  out  [N_MULT-1:0] FU_PACKET  MULT lane packets
- fu_load_packet  out  [N_LOAD-1:0] FU_PACKET  LOAD lane packets
- fu_store_packet  out  [N_STORE-1:0] FU_PACKET  STORE lane packets
- alu_free, mult_free, load_free, store_free  out  $clog2(Q_DEPTH+1) each  free entries per class, registered
- overflow  out  1  sticky error; set when an enqueue found its class FIFO full

Behaviour:
- Reset:
  - all FIFOs empty, head/tail = 0;
  - all *_free = Q_DEPTH;
  - overflow = 0;
  - every output packet .valid = 0.
- Each class is an independent circular FIFO.
  - head/tail pointers wrap modulo Q_DEPTH.
  - A count register distinguishes full from empty.
- Enqueue:
  - Valid issue lanes are taken in ascending lane index; same-class lanes append in that order (lane 0 is oldest).
  - Enqueued entries become visible at the next cycle.
  - There is no same-cycle bypass, so minimum issue-to-FU latency is 1 cycle.
- Presentation (combinational from FIFO state):
  - Let A = the available lanes of a class, in ascending index.
  - The k-th oldest entry drives the k-th lane in A, with .valid = 1, for k < min(count, |A|).
  - All other lanes of that class drive .valid = 0.
- Dequeue:
  - At the clock edge, head advances by min(count, |A|).
  - A packet is consumed exactly once, in the cycle it is shown on an avail lane.
  - If avail drops, the entry stays queued and is re-presented later in order.
- Simultaneous enqueue and dequeue on the same class:
  - count_next = count + enq - deq;
  - space freed this cycle is not usable by this cycle's enqueues (the full check uses the current count).
- Full:
  - Enqueues beyond Q_DEPTH - count in a cycle are dropped, lowest lanes first kept, and overflow is set.
  - overflow clears only on reset.
  - The RS must never send more than *_free entries of a class.
- *_free:
  - registered Q_DEPTH - count_next;
  - valid the cycle after an update.
- Squash (synchronous):
  - all FIFOs empty next cycle;
  - that cycle's enqueues are discarded;
  - all output .valid forced to 0 in the squash cycle;
  - *_free = Q_DEPTH next cycle;
  - overflow unaffected.
- Reset has priority over squash.
- Reset mid-operation discards all queued entries; no packet is emitted in the reset cycle.
- Payload fields other than .valid pass through unmodified.

Test Plan:
- Reset, then 3 ALU ADD packets on issue lanes 0-2, op1 = op2 = 1, with all alu_avail = 1 → the next cycle fu_alu_packet[0..2] are valid in lane order; after that cycle alu_free = 8.
- 2 MULT packets with robn 1 and 2, mult_avail = 0 for 3 cycles then 1 → no MULT valid while avail is low; both appear together once avail goes high, robn 1 on lane 0 and robn 2 on lane 1; mult_free goes 6 → 8.
- Fill the ALU FIFO to 8 while avail = 0, then send 1 more → the extra entry is dropped, overflow = 1, alu_free = 0; after raising avail, exactly 8 packets drain in FIFO order, including across the pointer wrap.
- alu_avail = 3'b101 with 3 queued ALU entries (robn 4, 5, 6) → robn 4 on lane 0 and robn 5 on lane 2; robn 6 is presented next cycle on lane 0.
- 5 mixed entries queued, then squash asserted together with 2 new issues → all output valids are 0 in the squash cycle and the next cycle; every *_free = 8.
- Simultaneous enqueue of 2 LOAD packets and dequeue of 1 LOAD with count = 7 → 1 packet is accepted, 1 is dropped, overflow = 1, load_free = 1.
